// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 stereo configuration path:
// arbiter state encoding, special table commands, default device ID
// and the round-robin owner selection helper.
package ov7670_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_e;

    localparam logic [15:0] CMD_END   = 16'hFFFF;
    localparam logic [15:0] CMD_DELAY = 16'hFFF0;
    localparam logic [7:0]  OV7670_ID = 8'h42;

    // Owner for the next grant: 0 = left, 1 = right. With both tables
    // pending the side opposite the previous owner wins.
    function automatic logic pick_owner(input logic pend_l,
                                        input logic pend_r,
                                        input logic last);
        logic owner;
        if (pend_l && pend_r) begin
            owner = ~last;
        end else if (pend_r) begin
            owner = 1'b1;
        end else begin
            owner = 1'b0;
        end
        return owner;
    endfunction

endpackage

// File: rtl/sccb_dual_cam_arbiter_if.sv
// Bundle between the dual-camera arbiter, the two register-table
// sequencers and the shared SCCB byte-write sender.
// master: the arbiter; slave: tables + sender side.
interface sccb_dual_cam_arbiter_if;
    logic [15:0] cmd_l;
    logic        done_l;
    logic        adv_l;
    logic [15:0] cmd_r;
    logic        done_r;
    logic        adv_r;
    logic        send;
    logic        taken;
    logic [7:0]  id;
    logic [7:0]  reg_addr;
    logic [7:0]  value;
    logic        bus_sel;
    logic        config_finished;

    modport master (
        input  cmd_l, done_l, cmd_r, done_r, taken,
        output adv_l, adv_r, send, id, reg_addr, value, bus_sel, config_finished
    );

    modport slave (
        output cmd_l, done_l, cmd_r, done_r, taken,
        input  adv_l, adv_r, send, id, reg_addr, value, bus_sel, config_finished
    );
endinterface

// File: rtl/sccb_dual_cam_arbiter_gap_timer.sv
// sccb_gap_timer: loadable down-counter shared by the post-write gap and
// the delay-command wait. expire flags the cycle whose decrement brings
// the count to zero, so the owner can leave its hold state on that edge.
module sccb_gap_timer #(
    parameter int GAP_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             expire
);

    logic [GAP_W-1:0] cnt_r;

    // Load takes priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {GAP_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {GAP_W{1'b0}})) begin
            cnt_r <= cnt_r - GAP_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r <= GAP_W'(1));

endmodule

// File: rtl/sccb_dual_cam_arbiter.sv
// sccb_dual_cam_arbiter: round-robin share of one SCCB byte-write sender
// between the left and right OV7670 register tables, with pin steering
// (bus_sel), per-write hold gap and config-complete reporting.
// Optional feature: define SCCB_DELAY_CMD_EN to turn table command
// 16'hFFF0 into a timed wait instead of a bus write.
module sccb_dual_cam_arbiter
    import ov7670_cfg_pkg::*;
#(
    parameter logic [7:0] ID_LEFT      = OV7670_ID,
    parameter logic [7:0] ID_RIGHT     = OV7670_ID,
    parameter int         GAP_CYCLES   = 2048,
    parameter int         GAP_W        = 12,
    parameter int         DELAY_CYCLES = 4000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sccb_dual_cam_arbiter_if.master   bus
);

    arb_state_e       state_r;
    logic             owner_r;
    logic             last_r;
    logic             send_r;
    logic             adv_l_r;
    logic             adv_r_r;
    logic             bus_sel_r;
    logic [7:0]       id_r;
    logic [7:0]       reg_addr_r;
    logic [7:0]       value_r;
    logic             config_finished_r;

    logic             pend_any_s;
    logic             grant_owner_s;
    logic [15:0]      grant_cmd_s;
    logic             done_owner_s;
    logic             is_delay_s;
    logic             timer_load_s;
    logic [GAP_W-1:0] timer_val_s;
    logic             timer_dec_s;
    logic             timer_expire_s;

    // Pending tables, round-robin choice and the candidate command.
    always_comb begin
        pend_any_s    = ~bus.done_l | ~bus.done_r;
        grant_owner_s = pick_owner(~bus.done_l, ~bus.done_r, last_r);
        grant_cmd_s   = grant_owner_s ? bus.cmd_r : bus.cmd_l;
        done_owner_s  = owner_r ? bus.done_r : bus.done_l;
`ifdef SCCB_DELAY_CMD_EN
        is_delay_s    = (grant_cmd_s == CMD_DELAY);
`else
        is_delay_s    = 1'b0;
`endif
    end

    // Timer control: load on entry to GAP/WAIT, count down while holding.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = {GAP_W{1'b0}};
        timer_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_any_s && is_delay_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = GAP_W'(DELAY_CYCLES - 1);
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (bus.taken) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_GAP, ST_WAIT: timer_dec_s = 1'b1;
            default:         timer_dec_s = 1'b0;
        endcase
    end

    sccb_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .dec      (timer_dec_s),
        .expire   (timer_expire_s)
    );

    // Arbiter FSM with all sender/table/pin outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            owner_r           <= 1'b0;
            last_r            <= 1'b1;
            send_r            <= 1'b0;
            adv_l_r           <= 1'b0;
            adv_r_r           <= 1'b0;
            bus_sel_r         <= 1'b0;
            id_r              <= ID_LEFT;
            reg_addr_r        <= 8'h00;
            value_r           <= 8'h00;
            config_finished_r <= 1'b0;
        end else begin
            adv_l_r <= 1'b0;
            adv_r_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pend_any_s) begin
                        owner_r           <= grant_owner_s;
                        last_r            <= grant_owner_s;
                        config_finished_r <= 1'b0;
                        if (is_delay_s) begin
                            // Delay command: retire it now, keep the pins where they are.
                            adv_l_r <= ~grant_owner_s;
                            adv_r_r <= grant_owner_s;
                            state_r <= ST_WAIT;
                        end else begin
                            bus_sel_r  <= grant_owner_s;
                            id_r       <= grant_owner_s ? ID_RIGHT : ID_LEFT;
                            reg_addr_r <= grant_cmd_s[15:8];
                            value_r    <= grant_cmd_s[7:0];
                            send_r     <= 1'b1;
                            state_r    <= ST_GRANT;
                        end
                    end else begin
                        config_finished_r <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (bus.taken) begin
                        send_r  <= 1'b0;
                        adv_l_r <= ~owner_r;
                        adv_r_r <= owner_r;
                        state_r <= ST_GAP;
                    end else if (done_owner_s) begin
                        // Table finished or aborted under us: withdraw silently.
                        send_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                ST_GAP, ST_WAIT: begin
                    if (timer_expire_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    send_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.send            = send_r;
    assign bus.adv_l           = adv_l_r;
    assign bus.adv_r           = adv_r_r;
    assign bus.bus_sel         = bus_sel_r;
    assign bus.id              = id_r;
    assign bus.reg_addr        = reg_addr_r;
    assign bus.value           = value_r;
    assign bus.config_finished = config_finished_r;

endmodule
